// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: MIPS funct codes, FSM encoding,
// iteration count and an operand magnitude helper.
package md_unit_pkg;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;

    localparam logic [5:0] MD_ITERS = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on magnitudes, sharing one adder, with a sign-fix step before commit.
//
// state | meaning
// IDLE  | waiting for a request; mthi/mtlo write here
// CALC  | 32 shift-add / restoring-divide iterations
// FIX   | sign correction, commit to hi/lo
// DONE  | done pulse; new requests accepted
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          r_state;
    logic [5:0]         r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_x;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_mul;
    logic               w_is_dv;
    logic               w_signed;
    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH+1:0]   w_add_a;
    logic [WIDTH+1:0]   w_add_b;
    logic [WIDTH+1:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_quo_neg;
    logic [WIDTH-1:0]   w_rem_neg;

    assign w_is_mul = (funct == FN_MULT) || (funct == FN_MULTU);
    assign w_is_dv  = (funct == FN_DIV)  || (funct == FN_DIVU);
    assign w_signed = (funct == FN_MULT) || (funct == FN_DIV);
    assign w_accept = start && !r_busy && !flush;
    assign w_abs_a  = md_abs(a, w_signed);
    assign w_abs_b  = md_abs(b, w_signed);

    // Divide subtracts the divisor from {rem, next dividend bit}; multiply adds
    // the multiplicand to the upper half when the current multiplier bit is set.
    assign w_add_a = r_is_div ? {1'b0, r_acc[2*WIDTH-1:WIDTH-1]}
                              : {2'b00, r_acc[2*WIDTH-1:WIDTH]};
    assign w_add_b = r_is_div ? ~{2'b00, r_x}
                              : {2'b00, (r_acc[0] ? r_x : {WIDTH{1'b0}})};
    assign w_sum   = w_add_a + w_add_b + {{(WIDTH+1){1'b0}}, r_is_div};

    assign w_prod_neg = ~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
    assign w_quo_neg  = ~r_acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_rem_neg  = ~r_acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 6'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_x      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == MD_ITERS) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (!r_is_div)
                            r_acc <= {w_sum[WIDTH:0], r_acc[WIDTH-1:1]};
                        else if (w_sum[WIDTH+1])
                            r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                        else
                            r_acc <= {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_is_div) begin
                            r_lo <= r_neg_q ? w_quo_neg : r_acc[WIDTH-1:0];
                            r_hi <= r_neg_r ? w_rem_neg : r_acc[2*WIDTH-1:WIDTH];
                        end else begin
                            r_lo <= r_neg_q ? w_prod_neg[WIDTH-1:0] : r_acc[WIDTH-1:0];
                            r_hi <= r_neg_q ? w_prod_neg[2*WIDTH-1:WIDTH]
                                            : r_acc[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        if (funct == FN_MTHI)
                            r_hi <= a;
                        if (funct == FN_MTLO)
                            r_lo <= a;
                        if (w_is_mul || w_is_dv) begin
                            r_state  <= ST_CALC;
                            r_busy   <= 1'b1;
                            r_cnt    <= 6'd0;
                            r_is_div <= w_is_dv;
                            r_x      <= w_is_dv ? w_abs_b : w_abs_a;
                            r_acc    <= {{WIDTH{1'b0}}, (w_is_dv ? w_abs_a : w_abs_b)};
                            // Divide by zero keeps an all-ones quotient unsigned.
                            r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1])
                                        && (w_is_mul || (b != '0));
                            r_neg_r  <= w_signed && w_is_dv && a[WIDTH-1];
                        end
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, signed/unsigned results,
// divide corner cases, mthi/mtlo, flush, ignored starts and mid-operation reset.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_pass = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drives a mult/div request now (just after an edge) and waits for done.
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        start = 1'b1;
        funct = fn;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        n = 61;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 33)
                chk({tag, " busy_before_done"}, 64'(busy), 64'd1);
            if (done) begin
                n = i;
                break;
            end
        end
        chk({tag, " latency"}, 64'(n), 64'd34);
        chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int saw_done;
        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        funct = 6'h00;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Unknown funct must be ignored.
        start = 1'b1;
        funct = 6'h20;
        a     = 32'h55;
        b     = 32'h3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("bad_funct busy", 64'(busy), 64'd0);

        // Back-to-back: each op is issued in the previous op's DONE cycle.
        run_op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",  FN_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div_neg",   FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", FN_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
        run_op("div_ovf",   FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // mthi issued in the DONE cycle.
        start = 1'b1;
        funct = FN_MTHI;
        a     = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mthi hi", 64'(hi), 64'h12345678);
        chk("mthi lo", 64'(lo), 64'h80000000);
        chk("mthi busy", 64'(busy), 64'd0);
        chk("mthi done", 64'(done), 64'd0);

        // Flush together with a valid start: request dropped.
        start = 1'b1;
        flush = 1'b1;
        funct = FN_MULTU;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start busy", 64'(busy), 64'd0);

        // multu 3*4, a stray mtlo at cycle 5, flush at cycle 10.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("flushop busy", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        funct = FN_MTLO;
        a     = 32'h0000DEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_ignored lo", 64'(lo), 64'h80000000);
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done)
                saw_done = 1;
        end
        chk("flush no_done", 64'(saw_done), 64'd0);
        chk("flush hi", 64'(hi), 64'h12345678);
        chk("flush lo", 64'(lo), 64'h80000000);

        // Reset in the middle of a divu, then divu 100/7.
        start = 1'b1;
        funct = FN_DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        #2;
        rst = 1'b1;
        run_op("divu_after_rst", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; this revision SHALL be used only with 32.
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request strobe from EX stage, sampled each rising edge.
REQ-006 funct  input  6  MIPS funct: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x11 mthi, 0x13 mtlo.
REQ-007 a  input  32  operand rs (dividend/multiplicand; mthi/mtlo source).
REQ-008 b  input  32  operand rt (divisor/multiplier).
REQ-009 flush  input  1  cancels any in-progress operation.
REQ-010 busy  output  1  operation in progress; new requests not accepted.
REQ-011 done  output  1  single-cycle pulse when a mult/div result is committed.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.

Function
REQ-014 A request SHALL be accepted at a rising edge only when start=1, busy=0, flush=0 and funct is one of the six codes; all other start pulses are ignored with no state change.
REQ-015 mthi/mtlo SHALL write a into hi/lo at the accept edge; busy stays 0, done stays 0.
REQ-016 FSM states: IDLE, CALC, FIX, DONE.
REQ-017 Transitions: IDLE->CALC on mult/div accept; CALC->FIX after exactly 32 iterations; FIX->DONE; DONE->IDLE.
REQ-018 At the accept edge the unit SHALL latch |a|, |b| (signed ops) or a, b (unsigned ops), result signs, and clear a 6-bit iteration counter.
REQ-019 CALC mult: radix-2 shift-add, one multiplier bit per cycle, 64-bit product register.
REQ-020 CALC div: restoring division, one quotient bit per cycle, 32-bit remainder + quotient registers.
REQ-021 FIX SHALL two's-complement-negate the product (sign a XOR sign b) for mult, the quotient (sign a XOR sign b) for div, and the remainder (sign of a) for div.
REQ-022 hi/lo SHALL update at the FIX->DONE edge; done=1 and busy=0 for exactly the DONE cycle.
REQ-023 Latency: accept edge k; hi/lo valid and done=1 in cycle after edge k+34; busy=1 from edge k through edge k+34.
REQ-024 mult/multu: hi=product[63:32], lo=product[31:0].
REQ-025 div/divu: lo=quotient, hi=remainder; remainder sign follows dividend.
REQ-026 Divide by zero (b=0): lo=0xFFFFFFFF, hi=a; same latency, no exception.
REQ-027 div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-028 flush in any non-IDLE state: return to IDLE at next edge; hi/lo unchanged; done not pulsed.
REQ-029 flush and a valid start in the same cycle: flush wins; request discarded.
REQ-030 A new request SHALL be accepted in the DONE cycle (back-to-back issue).

Reset
REQ-031 rst=0 SHALL asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0, counter and datapath registers to 0.
REQ-032 Reset asserted mid-operation SHALL discard the operation; after release the unit accepts requests on the first edge.

Structure
REQ-033 Shared package SHALL hold the six funct constants and the FSM state encoding; the pipeline decoder uses the same constants.
REQ-034 No sub-module: FSM, counter, and shared add/subtract datapath in one module.

Verification
REQ-035 multu a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 edges after accept, hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-038 div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 mthi 0x12345678 then multu 3*4 with flush at cycle 10 -> busy low next edge, hi=0x12345678, lo unchanged, no done; a start at cycle 5 of a busy op is ignored.
REQ-040 rst pulsed low at cycle 20 of a divu -> hi=lo=0, busy=0 immediately; divu 100/7 issued next cycle -> lo=14, hi=2.
